// File: rtl/sensor_stream_packer.sv
// Frames multi-channel sensor samples into a UART byte stream: HEADER, SEQ, data bytes MSB-first[, CSUM].
// Define SENSOR_PACKER_CHECKSUM_EN to append the checksum byte; by default the checksum logic is absent.
//
// state  | meaning
// IDLE   | no frame active, tx_valid low
// HDR    | presenting HEADER byte
// SEQ    | presenting sequence number
// DATA   | presenting data byte r_idx of the active frame
// CSUM   | presenting checksum (checksum build only)
module sensor_stream_packer #(
  parameter int          NUM_CH   = 3,
  parameter int          CH_BYTES = 3,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_valid,
  input  logic [NUM_CH*CH_BYTES*8-1:0] frame_data,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         pending_full,
  output logic [7:0]                   drop_count,
  output logic [7:0]                   seq_out
);

  localparam int NB = NUM_CH * CH_BYTES;
  localparam int FW = NB * 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEQ,
    S_DATA
`ifdef SENSOR_PACKER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [FW-1:0]   r_active;
  logic            r_active_vld;
  logic [FW-1:0]   r_pend;
  logic            r_pend_vld;
  logic [7:0]      r_tx_data;
  logic            r_tx_valid;
  logic [7:0]      r_seq;
  logic [7:0]      r_drop;
`ifdef SENSOR_PACKER_CHECKSUM_EN
  logic [7:0]      r_csum;
  logic [7:0]      w_csum_nxt;
`endif

  state_t          w_state_nxt;
  logic [IW-1:0]   w_idx_nxt;
  logic [7:0]      w_tx_data_nxt;
  logic            w_hs;
  logic            w_end;
  logic [IW-1:0]   w_byte_idx;
  logic [FW-1:0]   w_shifted;
  logic [7:0]      w_byte;

  assign w_hs       = r_tx_valid && tx_ready;
  // Byte needed next: byte 0 when leaving SEQ, otherwise the one after the current index.
  assign w_byte_idx = (r_state == S_SEQ) ? '0 : r_idx + 1'b1;
  assign w_shifted  = r_active << {w_byte_idx, 3'b000};
  assign w_byte     = w_shifted[FW-1 -: 8];

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_tx_data_nxt = r_tx_data;
    w_end         = 1'b0;
`ifdef SENSOR_PACKER_CHECKSUM_EN
    w_csum_nxt    = r_csum;
`endif
    case (r_state)
      S_IDLE: begin
        if (frame_valid) begin
          w_state_nxt   = S_HDR;
          w_tx_data_nxt = HEADER;
        end
      end
      S_HDR: begin
        if (w_hs) begin
          w_state_nxt   = S_SEQ;
          w_tx_data_nxt = r_seq;
`ifdef SENSOR_PACKER_CHECKSUM_EN
          w_csum_nxt    = r_seq;
`endif
        end
      end
      S_SEQ: begin
        if (w_hs) begin
          w_state_nxt   = S_DATA;
          w_idx_nxt     = '0;
          w_tx_data_nxt = w_byte;
        end
      end
      S_DATA: begin
        if (w_hs) begin
`ifdef SENSOR_PACKER_CHECKSUM_EN
          w_csum_nxt = r_csum + r_tx_data;
`endif
          if (r_idx == LAST_IDX) begin
`ifdef SENSOR_PACKER_CHECKSUM_EN
            w_state_nxt   = S_CSUM;
            w_tx_data_nxt = r_csum + r_tx_data;
`else
            w_end = 1'b1;
`endif
          end else begin
            w_idx_nxt     = r_idx + 1'b1;
            w_tx_data_nxt = w_byte;
          end
        end
      end
`ifdef SENSOR_PACKER_CHECKSUM_EN
      S_CSUM: begin
        if (w_hs) w_end = 1'b1;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase

    // A frame arriving on the final handshake is taken rather than dropped.
    if (w_end) begin
      if (r_pend_vld || frame_valid) begin
        w_state_nxt   = S_HDR;
        w_tx_data_nxt = HEADER;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_active     <= '0;
      r_active_vld <= 1'b0;
      r_pend       <= '0;
      r_pend_vld   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_seq        <= 8'h00;
      r_drop       <= 8'h00;
`ifdef SENSOR_PACKER_CHECKSUM_EN
      r_csum       <= 8'h00;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= (w_state_nxt != S_IDLE);
`ifdef SENSOR_PACKER_CHECKSUM_EN
      r_csum     <= w_csum_nxt;
`endif
      if (w_end) r_seq <= r_seq + 8'd1;

      if (r_state == S_IDLE) begin
        if (frame_valid) begin
          r_active     <= frame_data;
          r_active_vld <= 1'b1;
        end
      end else if (w_end) begin
        if (r_pend_vld) begin
          r_active <= r_pend;
          if (frame_valid) r_pend <= frame_data;
          else             r_pend_vld <= 1'b0;
        end else if (frame_valid) begin
          r_active <= frame_data;
        end else begin
          r_active_vld <= 1'b0;
        end
      end else if (frame_valid) begin
        if (!r_pend_vld) begin
          r_pend     <= frame_data;
          r_pend_vld <= 1'b1;
        end else if (r_drop != 8'hFF) begin
          r_drop <= r_drop + 8'd1;
        end
      end
    end
  end

  assign tx_data      = r_tx_data;
  assign tx_valid     = r_tx_valid;
  assign busy         = r_active_vld || r_pend_vld;
  assign pending_full = r_pend_vld;
  assign drop_count   = r_drop;
  assign seq_out      = r_seq;

endmodule

// File: tb/tb_sensor_stream_packer.sv
// Self-checking bench for sensor_stream_packer: vector table plus corner-case sequences,
// with a byte scoreboard filled when frames are driven and drained by a monitor.
module tb_sensor_stream_packer;

  localparam int FW = 72;
  localparam int NB = 9;
  localparam logic [7:0] HDR = 8'hA5;
`ifdef SENSOR_PACKER_CHECKSUM_EN
  localparam int PKT = NB + 3;
`else
  localparam int PKT = NB + 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_valid = 1'b0;
  logic [FW-1:0] frame_data = '0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          pending_full;
  logic [7:0]    drop_count;
  logic [7:0]    seq_out;

  sensor_stream_packer dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .pending_full(pending_full), .drop_count(drop_count), .seq_out(seq_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];
  logic [7:0] m_seq = 8'h00;
  int ready_mode = 0;  // 0 ready high, 1 toggle, 2 ready low

  typedef struct {
    logic [FW-1:0] data;
    logic [7:0]    sum;
    bit            bp;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // ready source
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       tx_ready = ~tx_ready;
        2:       tx_ready = 1'b0;
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // output monitor: scoreboard pop on handshake, stability across stalls
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, tx_valid}, 32'd1);
        check("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte got %0h expected none", tx_data);
        end else begin
          check("byte", {24'd0, tx_data}, {24'd0, sb_q.pop_front()});
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  function automatic logic [7:0] dsum(input logic [FW-1:0] d);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < NB; i++) s = s + d[FW-1-8*i -: 8];
    return s;
  endfunction

  task automatic push_pkt(input logic [FW-1:0] d, input logic [7:0] sum);
    sb_q.push_back(HDR);
    sb_q.push_back(m_seq);
    for (int i = 0; i < NB; i++) sb_q.push_back(d[FW-1-8*i -: 8]);
`ifdef SENSOR_PACKER_CHECKSUM_EN
    sb_q.push_back(m_seq + sum);
`endif
    m_seq = m_seq + 8'd1;
  endtask

  task automatic pulse(input logic [FW-1:0] d);
    frame_valid = 1'b1;
    frame_data  = d;
    @(posedge clk); #1;
    frame_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    m_seq = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_pending_full"}, {31'd0, pending_full}, 32'd0);
    check({tag, "_drop_count"}, {24'd0, drop_count}, 32'd0);
    check({tag, "_seq_out"}, {24'd0, seq_out}, 32'd0);
  endtask

  // drain until the scoreboard is empty and tx_valid is low; returns bubble count
  task automatic wait_idle(output int bubbles);
    int n = 0;
    bubbles = 0;
    while ((sb_q.size() != 0 || tx_valid) && n < 2000) begin
      @(negedge clk);
      if (!tx_valid && sb_q.size() != 0) bubbles++;
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d bytes left expected 0", sb_q.size());
    end
    @(posedge clk); #1;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_seq_out", {24'd0, seq_out}, {24'd0, m_seq});
  endtask

  initial begin
    int bub;
    logic [FW-1:0] d;

    vecs[0] = '{72'h010203040506070809, 8'h2D, 1'b0};
    vecs[1] = '{72'hFFFFFFFFFFFFFFFFFF, 8'hF7, 1'b1};
    vecs[2] = '{72'h000000000000000000, 8'h00, 1'b0};
    vecs[3] = '{72'h804020100804020100, 8'hFF, 1'b0};
    vecs[4] = '{72'h123456789ABCDEF011, 8'h49, 1'b1};

    do_reset();
    check_reset_outputs("reset");

    // latency: header visible the cycle after the strobe
    push_pkt(vecs[0].data, vecs[0].sum);
    pulse(vecs[0].data);
    check("latency_valid", {31'd0, tx_valid}, 32'd1);
    check("latency_header", {24'd0, tx_data}, {24'd0, HDR});
    wait_idle(bub);
    check("single_tx_valid_low", {31'd0, tx_valid}, 32'd0);
    check("single_seq_out", {24'd0, seq_out}, 32'h01);

    // table-driven frames, some under alternating backpressure
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ready_mode = vecs[i].bp ? 1 : 0;
      push_pkt(vecs[i].data, vecs[i].sum);
      pulse(vecs[i].data);
      wait_idle(bub);
      check("vec_tx_valid_low", {31'd0, tx_valid}, 32'd0);
    end
    ready_mode = 0;
    @(posedge clk); #1;

    // back-to-back A, B; C dropped during A's data
    do_reset();
    push_pkt(72'hA1A2A3A4A5A6A7A8A9, 8'h00 + dsum(72'hA1A2A3A4A5A6A7A8A9));
    pulse(72'hA1A2A3A4A5A6A7A8A9);
    @(posedge clk); #1;
    push_pkt(72'hB1B2B3B4B5B6B7B8B9, dsum(72'hB1B2B3B4B5B6B7B8B9));
    pulse(72'hB1B2B3B4B5B6B7B8B9);
    check("b2b_pending_full", {31'd0, pending_full}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    pulse(72'hC1C2C3C4C5C6C7C8C9);
    wait_idle(bub);
    check("b2b_bubbles", bub, 32'd0);
    check("b2b_drop_count", {24'd0, drop_count}, 32'd1);

    // frame arriving on the final handshake while pending is full
    do_reset();
    push_pkt(72'h111111111111111111, dsum(72'h111111111111111111));
    pulse(72'h111111111111111111);
    push_pkt(72'h222222222222222222, dsum(72'h222222222222222222));
    pulse(72'h222222222222222222);
    repeat (PKT - 2) @(posedge clk);
    #1;
    push_pkt(72'h333333333333333333, dsum(72'h333333333333333333));
    pulse(72'h333333333333333333);
    wait_idle(bub);
    check("boundary_drop_count", {24'd0, drop_count}, 32'd0);
    check("boundary_seq_out", {24'd0, seq_out}, 32'd3);
    check("boundary_bubbles", bub, 32'd0);

    // sequence wrap over 257 packets
    do_reset();
    for (int i = 0; i < 257; i++) begin
      d = {$urandom, $urandom, $urandom};
      push_pkt(d, dsum(d));
      pulse(d);
      wait_idle(bub);
      if (i == 255) check("wrap_seq_out_256", {24'd0, seq_out}, 32'd0);
    end
    check("wrap_seq_out_257", {24'd0, seq_out}, 32'd1);

    // drop counter saturation with the sink stalled
    do_reset();
    ready_mode = 2;
    @(posedge clk); #1;
    push_pkt(72'h0F0E0D0C0B0A090807, dsum(72'h0F0E0D0C0B0A090807));
    pulse(72'h0F0E0D0C0B0A090807);
    push_pkt(72'h5A5A5A5A5A5A5A5A5A, dsum(72'h5A5A5A5A5A5A5A5A5A));
    pulse(72'h5A5A5A5A5A5A5A5A5A);
    frame_valid = 1'b1;
    frame_data  = 72'hDEADBEEFDEADBEEFDE;
    repeat (300) @(posedge clk);
    #1;
    frame_valid = 1'b0;
    check("sat_drop_count", {24'd0, drop_count}, 32'hFF);
    check("sat_busy", {31'd0, busy}, 32'd1);
    check("sat_pending_full", {31'd0, pending_full}, 32'd1);
    ready_mode = 0;
    wait_idle(bub);
    check("sat_drop_hold", {24'd0, drop_count}, 32'hFF);

    // reset mid-data, then a clean packet
    do_reset();
    push_pkt(72'h998877665544332211, dsum(72'h998877665544332211));
    pulse(72'h998877665544332211);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    sb_q.delete();
    m_seq = 8'h00;
    push_pkt(72'h0102030405060708AA, dsum(72'h0102030405060708AA));
    pulse(72'h0102030405060708AA);
    wait_idle(bub);
    check("after_reset_seq_out", {24'd0, seq_out}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
